// File: rtl/button_conditioner.sv
// Six-button front end: 2-FF synchronizer, ms-tick debounce, sticky short events,
// and long-press detection on the reset/test buttons.
module button_conditioner #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 5000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] btn_raw,
  input  logic [5:0] evt_clr,
  output logic [5:0] btn_level,
  output logic [5:0] evt,
  output logic [1:0] long_evt,
  output logic       tick_ms
);

  localparam int unsigned TDIV =
    (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned TW =
    (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned DW =
    (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam int unsigned HW =
    (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

  localparam logic [TW-1:0] TTERM = TW'(TDIV - 1);
  localparam logic [DW-1:0] DTERM = DW'(DEBOUNCE_MS);
  localparam logic [HW-1:0] HTERM = HW'(LONG_MS);
  localparam logic [5:0]    RAW_IDLE = {6{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_LONG
  } hold_e;

  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    sync1_q, sync2_q, sync;
  logic [DW-1:0] db_q [6];
  logic [DW-1:0] db_d [6];
  logic [5:0]    level_q, level_d;
  logic [5:0]    prev_q;
  hold_e         st_q [2];
  hold_e         st_d [2];
  logic [HW-1:0] hc_q [2];
  logic [HW-1:0] hc_d [2];
  logic [1:0]    short_set, long_set;
  logic [5:0]    evt_q, evt_d, evt_set;
  logic [1:0]    long_q, long_d;

  assign tick_ms = (tick_q == TTERM);
  assign tick_d  = tick_ms ? '0 : tick_q + TW'(1);

  assign sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Counter only advances while the input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 6; i++) begin
      db_d[i] = db_q[i];
      if (sync[i] == level_q[i]) begin
        db_d[i] = '0;
      end else if (tick_ms) begin
        if (db_q[i] + DW'(1) == DTERM) begin
          level_d[i] = sync[i];
          db_d[i]    = '0;
        end else begin
          db_d[i] = db_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      st_d[j]      = st_q[j];
      hc_d[j]      = hc_q[j];
      short_set[j] = 1'b0;
      long_set[j]  = 1'b0;
      unique case (st_q[j])
        S_IDLE: begin
          hc_d[j] = '0;
          if (level_q[4+j]) st_d[j] = S_HELD;
        end
        S_HELD: begin
          if (!level_q[4+j]) begin
            st_d[j]      = S_IDLE;
            short_set[j] = 1'b1;
          end else if (tick_ms) begin
            hc_d[j] = hc_q[j] + HW'(1);
            if (hc_q[j] + HW'(1) == HTERM) begin
              st_d[j]     = S_LONG;
              long_set[j] = 1'b1;
            end
          end
        end
        S_LONG: begin
          if (!level_q[4+j]) st_d[j] = S_IDLE;
        end
        default: st_d[j] = S_IDLE;
      endcase
    end
  end

  // A set in the same cycle as its clear must survive.
  assign evt_set = {short_set, level_q[3:0] & ~prev_q[3:0]};
  assign evt_d   = evt_set | (evt_q & ~evt_clr);
  assign long_d  = long_set | (long_q & ~evt_clr[5:4]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      level_q <= '0;
      prev_q  <= '0;
      evt_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < 6; i++) db_q[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        st_q[j] <= S_IDLE;
        hc_q[j] <= '0;
      end
    end else begin
      tick_q  <= tick_d;
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      evt_q   <= evt_d;
      long_q  <= long_d;
      for (int i = 0; i < 6; i++) db_q[i] <= db_d[i];
      for (int j = 0; j < 2; j++) begin
        st_q[j] <= st_d[j];
        hc_q[j] <= hc_d[j];
      end
    end
  end

  assign btn_level = level_q;
  assign evt       = evt_q;
  assign long_evt  = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random checks of button_conditioner against a
// timestamp-based reference model.
module tb_button_conditioner;

  localparam int CF   = 10_000;
  localparam int DB   = 4;
  localparam int LG   = 20;
  localparam int TDIV = CF / 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn_raw;
  logic [5:0] evt_clr;
  logic [5:0] btn_level;
  logic [5:0] evt;
  logic [1:0] long_evt;
  logic       tick_ms;

  button_conditioner #(
    .CLK_FREQ   (CF),
    .DEBOUNCE_MS(DB),
    .LONG_MS    (LG),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .evt_clr  (evt_clr),
    .btn_level(btn_level),
    .evt      (evt),
    .long_evt (long_evt),
    .tick_ms  (tick_ms)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time is measured in elapsed ms ticks; a level is
  // accepted once the input has disagreed for DB ticks, a long press once
  // the level has been held for LG ticks.
  int         m_cyc, m_ticks;
  logic [5:0] h1, h2;
  logic [5:0] m_lvl, m_prev, m_evt;
  logic [1:0] m_long;
  int         db_start [6];
  int         hold_start [2];
  bit         long_done [2];

  task automatic model_reset();
    m_cyc   = 0;
    m_ticks = 0;
    h1      = 6'h3F;
    h2      = 6'h3F;
    m_lvl   = '0;
    m_prev  = '0;
    m_evt   = '0;
    m_long  = '0;
    for (int i = 0; i < 6; i++) db_start[i] = -1;
    for (int j = 0; j < 2; j++) begin
      hold_start[j] = -1;
      long_done[j]  = 1'b0;
    end
  endtask

  task automatic model_update();
    bit         tick;
    int         now;
    logic [5:0] syn, nl, set;
    logic [1:0] lset;
    tick = ((m_cyc % TDIV) == TDIV - 1);
    now  = m_ticks + (tick ? 1 : 0);
    syn  = ~h2;
    nl   = m_lvl;
    set  = '0;
    lset = '0;
    for (int i = 0; i < 6; i++) begin
      if (syn[i] != m_lvl[i]) begin
        if (db_start[i] < 0) db_start[i] = m_ticks;
        if (tick && (now - db_start[i] == DB)) begin
          nl[i]       = syn[i];
          db_start[i] = -1;
        end
      end else begin
        db_start[i] = -1;
      end
    end
    set[3:0] = m_lvl[3:0] & ~m_prev[3:0];
    for (int j = 0; j < 2; j++) begin
      if (long_done[j]) begin
        if (!m_lvl[4+j]) long_done[j] = 1'b0;
      end else if (hold_start[j] < 0) begin
        if (m_lvl[4+j]) hold_start[j] = now;
      end else if (!m_lvl[4+j]) begin
        set[4+j]      = 1'b1;
        hold_start[j] = -1;
      end else if (tick && (now - hold_start[j] == LG)) begin
        lset[j]       = 1'b1;
        long_done[j]  = 1'b1;
        hold_start[j] = -1;
      end
    end
    m_evt   = set | (m_evt & ~evt_clr);
    m_long  = lset | (m_long & ~evt_clr[5:4]);
    m_prev  = m_lvl;
    m_lvl   = nl;
    h2      = h1;
    h1      = btn_raw;
    m_ticks = now;
    m_cyc   = m_cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs,
                     input logic [5:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic t;
    t = ((m_cyc % TDIV) == TDIV - 1);
    chk("level", btn_level, m_lvl);
    chk("evt", evt, m_evt);
    chk("long_evt", 6'(long_evt), 6'(m_long));
    chk("tick_ms", 6'(tick_ms), 6'(t));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_clr(input logic [5:0] m);
    evt_clr = m;
    step();
    evt_clr = '0;
  endtask

  initial begin
    int ticks_seen;
    bit found;
    reset   = 1'b1;
    btn_raw = 6'h3F;
    evt_clr = '0;
    model_reset();
    steps(3);
    reset = 1'b0;

    // Idle: ten-cycle tick, everything quiet
    ticks_seen = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tick_ms) ticks_seen++;
    end
    chk("idle_ticks", 6'(ticks_seen), 6'd20);
    chk("idle_out", btn_level | evt, 6'h00);

    // Bounce shorter than the debounce time
    btn_raw[0] = 1'b0;
    steps(25);
    btn_raw[0] = 1'b1;
    steps(60);
    chk("bounce_lvl0", 6'(btn_level[0]), 6'd0);
    chk("bounce_evt0", 6'(evt[0]), 6'd0);

    // Clean press of bit 2, sticky until cleared
    btn_raw[2] = 1'b0;
    steps(44);
    chk("press_lvl2", 6'(btn_level[2]), 6'd1);
    chk("press_evt2", 6'(evt[2]), 6'd1);
    steps(56);
    btn_raw[2] = 1'b1;
    steps(60);
    chk("sticky_evt2", 6'(evt[2]), 6'd1);
    pulse_clr(6'b000100);
    step();
    chk("clr_evt2", 6'(evt[2]), 6'd0);

    // Short press of the reset button
    btn_raw[4] = 1'b0;
    steps(100);
    btn_raw[4] = 1'b1;
    steps(60);
    chk("short_evt4", 6'(evt[4]), 6'd1);
    chk("short_long0", 6'(long_evt[0]), 6'd0);
    pulse_clr(6'b010000);

    // Long press of the test button, cleared while still held
    btn_raw[5] = 1'b0;
    steps(280);
    chk("long1_set", 6'(long_evt[1]), 6'd1);
    pulse_clr(6'b100000);
    steps(70);
    chk("long1_noretrig", 6'(long_evt[1]), 6'd0);
    btn_raw[5] = 1'b1;
    steps(60);
    chk("long_no_evt5", 6'(evt[5]), 6'd0);
    chk("long1_after", 6'(long_evt[1]), 6'd0);

    // Clear held high across the cycle evt[1] sets
    evt_clr    = 6'b000010;
    btn_raw[1] = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      step();
      if (m_evt[1]) found = 1'b1;
    end
    chk("setwin_found", 6'(found), 6'd1);
    chk("setwin_evt1", 6'(evt[1]), 6'd1);
    evt_clr    = '0;
    btn_raw[1] = 1'b1;
    steps(60);
    chk("setwin_hold", 6'(evt[1]), 6'd1);
    pulse_clr(6'b000010);

    // Reset in the middle of a bit-4 hold
    btn_raw[4] = 1'b0;
    steps(120);
    reset = 1'b1;
    model_reset();
    steps(3);
    btn_raw[4] = 1'b1;
    reset = 1'b0;
    steps(300);
    chk("rst_hold_evt4", 6'(evt[4]), 6'd0);
    chk("rst_hold_long0", 6'(long_evt[0]), 6'd0);

    // Button already down when reset releases
    btn_raw[3] = 1'b0;
    reset = 1'b1;
    model_reset();
    steps(3);
    reset = 1'b0;
    steps(20);
    chk("rst_held_lvl3", 6'(btn_level[3]), 6'd0);
    chk("rst_held_evt3", 6'(evt[3]), 6'd0);
    steps(40);
    chk("rst_held_late", 6'(evt[3]), 6'd1);
    btn_raw[3] = 1'b1;
    steps(60);

    // Random button patterns and clear strobes
    for (int s = 0; s < 24; s++) begin
      int dur;
      btn_raw = 6'($urandom);
      dur     = $urandom_range(5, 300);
      for (int k = 0; k < dur; k++) begin
        evt_clr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
        step();
      end
    end
    evt_clr = '0;
    btn_raw = 6'h3F;
    steps(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
